// File: rtl/tile_sel_ctrl_pkg.sv
// Shared constants for the tile selector and the RGB mux: select codes, map
// codes, map geometry and the overlay object snapshot taken at frame start.
package tile_sel_ctrl_pkg;

  localparam int TILE_BITS    = 6;
  localparam int MAP_W        = 16;
  localparam int MAP_H        = 12;
  localparam int MAP_AW       = 8;
  localparam int BLINK_FRAMES = 8;
  localparam int SYNC_DLY     = 4;

  localparam logic [3:0] T_PATH  = 4'd0;
  localparam logic [3:0] T_SURR  = 4'd1;
  localparam logic [3:0] T_OBS1  = 4'd2;
  localparam logic [3:0] T_OBS2  = 4'd3;
  localparam logic [3:0] T_BOMB  = 4'd4;
  localparam logic [3:0] T_EXPL  = 4'd5;
  localparam logic [3:0] T_PLR1  = 4'd6;
  localparam logic [3:0] T_PLR2  = 4'd7;
  localparam logic [3:0] T_BLANK = 4'hF;

  typedef enum logic [1:0] {
    MC_PATH = 2'b00,
    MC_SURR = 2'b01,
    MC_OBS1 = 2'b10,
    MC_OBS2 = 2'b11
  } map_code_e;

  typedef struct packed {
    logic [3:0] p1x;
    logic [3:0] p1y;
    logic [3:0] p2x;
    logic [3:0] p2y;
    logic       p1hit;
    logic       p2hit;
    logic       bomb_vld;
    logic [3:0] bx;
    logic [3:0] by;
    logic       expl_vld;
    logic [3:0] ex;
    logic [3:0] ey;
    logic [1:0] rng;
  } obj_t;

  // Widened to 5 bits so the difference never wraps across the map edge.
  function automatic logic [4:0] abs_diff4(input logic [3:0] a, input logic [3:0] b);
    return (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
  endfunction

endpackage

// File: rtl/tile_sel_ctrl_expl_cover.sv
// Combinational cross-shape test: is tile (tx,ty) within an explosion arm of
// length rng centred on (ex,ey).
module tile_sel_ctrl_expl_cover
  import tile_sel_ctrl_pkg::*;
(
  input  logic       i_vld,
  input  logic [3:0] i_tx,
  input  logic [3:0] i_ty,
  input  logic [3:0] i_ex,
  input  logic [3:0] i_ey,
  input  logic [1:0] i_rng,
  output logic       o_cover
);

  logic [4:0] dx;
  logic [4:0] dy;
  logic [4:0] rng5;

  assign dx   = abs_diff4(i_tx, i_ex);
  assign dy   = abs_diff4(i_ty, i_ey);
  assign rng5 = {3'b000, i_rng};

  assign o_cover = i_vld &&
                   (((i_ty == i_ey) && (dx <= rng5)) ||
                    ((i_tx == i_ex) && (dy <= rng5)));

endmodule

// File: rtl/tile_sel_ctrl.sv
// Per-pixel tile scheduler: map fetch, overlay arbitration and mux select with
// a two-stage pipeline, plus timing signals delayed to match the mux output.
module tile_sel_ctrl #(
  parameter int TILE_BITS    = tile_sel_ctrl_pkg::TILE_BITS,
  parameter int MAP_W        = tile_sel_ctrl_pkg::MAP_W,
  parameter int MAP_H        = tile_sel_ctrl_pkg::MAP_H,
  parameter int MAP_AW       = tile_sel_ctrl_pkg::MAP_AW,
  parameter int BLINK_FRAMES = tile_sel_ctrl_pkg::BLINK_FRAMES,
  parameter int SYNC_DLY     = tile_sel_ctrl_pkg::SYNC_DLY
) (
  input  logic                   i_pclk,
  input  logic                   i_rst,
  input  logic [10:0]            i_hcount,
  input  logic [10:0]            i_vcount,
  input  logic                   i_hsync,
  input  logic                   i_vsync,
  input  logic                   i_hblnk,
  input  logic                   i_vblnk,
  output logic [MAP_AW-1:0]      o_map_addr,
  input  logic [1:0]             i_map_data,
  input  logic [3:0]             i_plr1_x,
  input  logic [3:0]             i_plr1_y,
  input  logic [3:0]             i_plr2_x,
  input  logic [3:0]             i_plr2_y,
  input  logic                   i_plr1_hit,
  input  logic                   i_plr2_hit,
  input  logic                   i_bomb_vld,
  input  logic [3:0]             i_bomb_x,
  input  logic [3:0]             i_bomb_y,
  input  logic                   i_expl_vld,
  input  logic [3:0]             i_expl_x,
  input  logic [3:0]             i_expl_y,
  input  logic [1:0]             i_expl_rng,
  output logic [3:0]             o_sel,
  output logic [2*TILE_BITS-1:0] o_rom_addr,
  output logic                   o_hsync,
  output logic                   o_vsync,
  output logic                   o_hblnk,
  output logic                   o_vblnk
);

  import tile_sel_ctrl_pkg::*;

  localparam int TCW = 11 - TILE_BITS;
  localparam int FCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // Stage 1: tile coordinates and map address
  logic [TCW-1:0]       tile_x;
  logic [TCW-1:0]       tile_y;
  logic                 oom_d;
  logic [MAP_AW-1:0]    map_addr_d;

  logic [MAP_AW-1:0]    map_addr_q;
  logic [TILE_BITS-1:0] pix_x_q;
  logic [TILE_BITS-1:0] pix_y_q;
  logic [3:0]           tile_x_q;
  logic [3:0]           tile_y_q;
  logic                 blank_q;
  logic                 oom_q;

  assign tile_x     = i_hcount[10:TILE_BITS];
  assign tile_y     = i_vcount[10:TILE_BITS];
  assign oom_d      = (32'(tile_x) >= MAP_W) || (32'(tile_y) >= MAP_H);
  assign map_addr_d = oom_d ? '0 : MAP_AW'(32'(tile_y) * MAP_W + 32'(tile_x));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge i_pclk or posedge i_rst) begin
    if (i_rst) begin
      map_addr_q <= '0;
      pix_x_q    <= '0;
      pix_y_q    <= '0;
      tile_x_q   <= '0;
      tile_y_q   <= '0;
      blank_q    <= 1'b1;
      oom_q      <= 1'b0;
    end else begin
      map_addr_q <= map_addr_d;
      pix_x_q    <= i_hcount[TILE_BITS-1:0];
      pix_y_q    <= i_vcount[TILE_BITS-1:0];
      tile_x_q   <= 4'(tile_x);
      tile_y_q   <= 4'(tile_y);
      blank_q    <= i_hblnk | i_vblnk;
      oom_q      <= oom_d;
    end
  end

  // Frame-start snapshot of overlays and blink phase
  obj_t           obj_in;
  obj_t           obj_q;
  logic           vsync_q;
  logic           vs_rise;
  logic [FCW-1:0] frame_cnt_q;
  logic           phase_q;

  assign vs_rise = i_vsync & ~vsync_q;
  assign obj_in  = '{p1x: i_plr1_x, p1y: i_plr1_y, p2x: i_plr2_x, p2y: i_plr2_y,
                     p1hit: i_plr1_hit, p2hit: i_plr2_hit,
                     bomb_vld: i_bomb_vld, bx: i_bomb_x, by: i_bomb_y,
                     expl_vld: i_expl_vld, ex: i_expl_x, ey: i_expl_y,
                     rng: i_expl_rng};

  always_ff @(posedge i_pclk or posedge i_rst) begin
    if (i_rst) begin
      vsync_q     <= 1'b0;
      obj_q       <= '0;
      frame_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      vsync_q <= i_vsync;
      if (vs_rise) begin
        obj_q <= obj_in;
        if (frame_cnt_q == FCW'(BLINK_FRAMES - 1)) begin
          frame_cnt_q <= '0;
          phase_q     <= ~phase_q;
        end else begin
          frame_cnt_q <= frame_cnt_q + 1'b1;
        end
      end
    end
  end

  // Stage 2: arbitration
  map_code_e map_code;
  logic      expl_cov;
  logic      plr1_vis;
  logic      plr2_vis;
  logic      expl_hit;
  logic      bomb_hit;
  logic [3:0] sel_d;
  logic [3:0] sel_q;
  logic [2*TILE_BITS-1:0] rom_addr_q;

  assign map_code = map_code_e'(i_map_data);

  tile_sel_ctrl_expl_cover u_expl_cover (
    .i_vld   (obj_q.expl_vld),
    .i_tx    (tile_x_q),
    .i_ty    (tile_y_q),
    .i_ex    (obj_q.ex),
    .i_ey    (obj_q.ey),
    .i_rng   (obj_q.rng),
    .o_cover (expl_cov)
  );

  assign plr1_vis = (tile_x_q == obj_q.p1x) && (tile_y_q == obj_q.p1y) &&
                    !(obj_q.p1hit && phase_q);
  assign plr2_vis = (tile_x_q == obj_q.p2x) && (tile_y_q == obj_q.p2y) &&
                    !(obj_q.p2hit && phase_q);
  assign expl_hit = expl_cov && ((map_code == MC_PATH) || (map_code == MC_OBS1));
  assign bomb_hit = obj_q.bomb_vld && (tile_x_q == obj_q.bx) &&
                    (tile_y_q == obj_q.by) && (map_code == MC_PATH);

  // NOTE: default first so every path assigns sel_d and no latch is inferred.
  always_comb begin
    sel_d = {2'b00, i_map_data};
    if (blank_q)       sel_d = T_BLANK;
    else if (oom_q)    sel_d = T_SURR;
    else if (plr1_vis) sel_d = T_PLR1;
    else if (plr2_vis) sel_d = T_PLR2;
    else if (expl_hit) sel_d = T_EXPL;
    else if (bomb_hit) sel_d = T_BOMB;
  end

  always_ff @(posedge i_pclk or posedge i_rst) begin
    if (i_rst) begin
      sel_q      <= T_BLANK;
      rom_addr_q <= '0;
    end else begin
      sel_q      <= sel_d;
      rom_addr_q <= {pix_y_q, pix_x_q};
    end
  end

  // Timing delay line lined up with ROM + mux latency downstream
  logic [SYNC_DLY-1:0] hs_q;
  logic [SYNC_DLY-1:0] vs_q;
  logic [SYNC_DLY-1:0] hb_q;
  logic [SYNC_DLY-1:0] vb_q;

  always_ff @(posedge i_pclk or posedge i_rst) begin
    if (i_rst) begin
      hs_q <= '0;
      vs_q <= '0;
      hb_q <= '0;
      vb_q <= '0;
    end else begin
      hs_q <= {hs_q[SYNC_DLY-2:0], i_hsync};
      vs_q <= {vs_q[SYNC_DLY-2:0], i_vsync};
      hb_q <= {hb_q[SYNC_DLY-2:0], i_hblnk};
      vb_q <= {vb_q[SYNC_DLY-2:0], i_vblnk};
    end
  end

  assign o_map_addr = map_addr_q;
  assign o_sel      = sel_q;
  assign o_rom_addr = rom_addr_q;
  assign o_hsync    = hs_q[SYNC_DLY-1];
  assign o_vsync    = vs_q[SYNC_DLY-1];
  assign o_hblnk    = hb_q[SYNC_DLY-1];
  assign o_vblnk    = vb_q[SYNC_DLY-1];

endmodule

// File: tb/tb_tile_sel_ctrl.sv
// Directed bench for tile_sel_ctrl with a behavioural map RAM and
// hand-computed select codes.
module tb_tile_sel_ctrl;

  logic        i_pclk = 1'b0;
  logic        i_rst;
  logic [10:0] i_hcount, i_vcount;
  logic        i_hsync, i_vsync, i_hblnk, i_vblnk;
  logic [7:0]  o_map_addr;
  logic [1:0]  i_map_data;
  logic [3:0]  i_plr1_x, i_plr1_y, i_plr2_x, i_plr2_y;
  logic        i_plr1_hit, i_plr2_hit;
  logic        i_bomb_vld;
  logic [3:0]  i_bomb_x, i_bomb_y;
  logic        i_expl_vld;
  logic [3:0]  i_expl_x, i_expl_y;
  logic [1:0]  i_expl_rng;
  logic [3:0]  o_sel;
  logic [11:0] o_rom_addr;
  logic        o_hsync, o_vsync, o_hblnk, o_vblnk;

  logic [1:0]  map_mem [256];
  int          n_assert = 0;
  int          n_fail   = 0;

  tile_sel_ctrl dut (
    .i_pclk     (i_pclk),
    .i_rst      (i_rst),
    .i_hcount   (i_hcount),
    .i_vcount   (i_vcount),
    .i_hsync    (i_hsync),
    .i_vsync    (i_vsync),
    .i_hblnk    (i_hblnk),
    .i_vblnk    (i_vblnk),
    .o_map_addr (o_map_addr),
    .i_map_data (i_map_data),
    .i_plr1_x   (i_plr1_x),
    .i_plr1_y   (i_plr1_y),
    .i_plr2_x   (i_plr2_x),
    .i_plr2_y   (i_plr2_y),
    .i_plr1_hit (i_plr1_hit),
    .i_plr2_hit (i_plr2_hit),
    .i_bomb_vld (i_bomb_vld),
    .i_bomb_x   (i_bomb_x),
    .i_bomb_y   (i_bomb_y),
    .i_expl_vld (i_expl_vld),
    .i_expl_x   (i_expl_x),
    .i_expl_y   (i_expl_y),
    .i_expl_rng (i_expl_rng),
    .o_sel      (o_sel),
    .o_rom_addr (o_rom_addr),
    .o_hsync    (o_hsync),
    .o_vsync    (o_vsync),
    .o_hblnk    (o_hblnk),
    .o_vblnk    (o_vblnk)
  );

  always #5 i_pclk = ~i_pclk;

  // Map RAM: address registered by the DUT, data ready before the next edge
  always @(negedge i_pclk) i_map_data <= map_mem[o_map_addr];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge i_pclk);
    #1;
  endtask

  task automatic show(input int tx, input int ty, input int px, input int py);
    i_hcount = 11'(tx * 64 + px);
    i_vcount = 11'(ty * 64 + py);
    tick(2);
  endtask

  task automatic vs_pulse(input int n);
    for (int k = 0; k < n; k++) begin
      i_vsync = 1'b1;
      tick(2);
      i_vsync = 1'b0;
      tick(2);
    end
  endtask

  task automatic map_fill_path;
    for (int a = 0; a < 256; a++) map_mem[a] = 2'b00;
  endtask

  initial begin
    map_fill_path();
    i_rst = 1'b1;
    i_hcount = 11'd500; i_vcount = 11'd300;
    i_hsync = 1'b1; i_vsync = 1'b0; i_hblnk = 1'b0; i_vblnk = 1'b0;
    i_plr1_x = 4'd0; i_plr1_y = 4'd0; i_plr2_x = 4'd0; i_plr2_y = 4'd0;
    i_plr1_hit = 1'b0; i_plr2_hit = 1'b0;
    i_bomb_vld = 1'b0; i_bomb_x = 4'd0; i_bomb_y = 4'd0;
    i_expl_vld = 1'b0; i_expl_x = 4'd0; i_expl_y = 4'd0; i_expl_rng = 2'd0;
    tick(3);
    check("rst_sel", 16'(o_sel), 16'hF);
    check("rst_map_addr", 16'(o_map_addr), 16'h0);
    check("rst_rom_addr", 16'(o_rom_addr), 16'h0);
    check("rst_hsync", 16'(o_hsync), 16'h0);

    // First pixel after release: (70,130) -> tile (1,2), pixel (6,2)
    map_mem[8'h21] = 2'b10;
    i_hsync  = 1'b0;
    i_hcount = 11'd70; i_vcount = 11'd130;
    i_rst    = 1'b0;
    tick(1);
    check("lat_map_addr", 16'(o_map_addr), 16'h21);
    tick(1);
    check("lat_sel", 16'(o_sel), 16'h2);
    check("lat_rom_addr", 16'(o_rom_addr), 16'h086);

    // Both players on (3,4); frame counter reaches 1
    i_plr1_x = 4'd3; i_plr1_y = 4'd4; i_plr2_x = 4'd3; i_plr2_y = 4'd4;
    vs_pulse(1);
    show(3, 4, 10, 5);
    check("both_plr", 16'(o_sel), 16'h6);

    // Hit blink: phase flips on the 8th, 16th ... vsync edge since reset
    i_plr1_hit = 1'b1;
    vs_pulse(1);
    show(3, 4, 10, 5);
    check("blink_f2", 16'(o_sel), 16'h6);
    vs_pulse(5);
    show(3, 4, 10, 5);
    check("blink_f7", 16'(o_sel), 16'h6);
    vs_pulse(1);
    show(3, 4, 10, 5);
    check("blink_f8", 16'(o_sel), 16'h7);
    vs_pulse(7);
    show(3, 4, 10, 5);
    check("blink_f15", 16'(o_sel), 16'h7);
    vs_pulse(1);
    show(3, 4, 10, 5);
    check("blink_f16", 16'(o_sel), 16'h6);
    i_plr1_hit = 1'b0;
    vs_pulse(1);

    // Mid-frame input change must wait for the next vsync edge
    i_plr1_x = 4'd9;
    show(3, 4, 1, 1);
    check("mid_old_pos", 16'(o_sel), 16'h6);
    show(9, 4, 1, 1);
    check("mid_new_pos", 16'(o_sel), 16'h0);
    vs_pulse(1);
    show(3, 4, 1, 1);
    check("post_old_pos", 16'(o_sel), 16'h7);
    show(9, 4, 1, 1);
    check("post_new_pos", 16'(o_sel), 16'h6);

    // Explosion at (5,5) rng 2; obs2 at (7,5), obs1 at (4,5), surr at (5,6)
    i_plr1_x = 4'd15; i_plr1_y = 4'd11; i_plr2_x = 4'd15; i_plr2_y = 4'd11;
    map_mem[5*16+7] = 2'b11;
    map_mem[5*16+4] = 2'b10;
    map_mem[6*16+5] = 2'b01;
    i_expl_vld = 1'b1; i_expl_x = 4'd5; i_expl_y = 4'd5; i_expl_rng = 2'd2;
    i_bomb_vld = 1'b1; i_bomb_x = 4'd10; i_bomb_y = 4'd10;
    vs_pulse(1);
    show(5, 5, 0, 0);  check("expl_ctr", 16'(o_sel), 16'h5);
    show(3, 5, 0, 0);  check("expl_3_5", 16'(o_sel), 16'h5);
    show(4, 5, 0, 0);  check("expl_obs1", 16'(o_sel), 16'h5);
    show(6, 5, 63, 63); check("expl_6_5", 16'(o_sel), 16'h5);
    show(7, 5, 0, 0);  check("expl_obs2", 16'(o_sel), 16'h3);
    show(8, 5, 0, 0);  check("expl_8_5", 16'(o_sel), 16'h0);
    show(2, 5, 0, 0);  check("expl_2_5", 16'(o_sel), 16'h0);
    show(5, 3, 0, 0);  check("expl_5_3", 16'(o_sel), 16'h5);
    show(5, 7, 0, 0);  check("expl_5_7", 16'(o_sel), 16'h5);
    show(5, 8, 0, 0);  check("expl_5_8", 16'(o_sel), 16'h0);
    show(5, 6, 0, 0);  check("expl_surr", 16'(o_sel), 16'h1);
    show(6, 6, 0, 0);  check("expl_diag", 16'(o_sel), 16'h0);
    show(10, 10, 0, 0); check("bomb_path", 16'(o_sel), 16'h4);
    show(15, 11, 0, 0); check("plr_corner", 16'(o_sel), 16'h6);

    // Bomb under explosion on a path tile
    i_bomb_x = 4'd6; i_bomb_y = 4'd5;
    vs_pulse(1);
    show(6, 5, 0, 0);  check("bomb_in_expl", 16'(o_sel), 16'h5);
    show(10, 10, 0, 0); check("bomb_moved", 16'(o_sel), 16'h0);

    // Explosion at the corner must not wrap
    map_fill_path();
    i_bomb_vld = 1'b0;
    i_expl_x = 4'd0; i_expl_y = 4'd0; i_expl_rng = 2'd3;
    vs_pulse(1);
    show(15, 0, 0, 0); check("nowrap_15_0", 16'(o_sel), 16'h0);
    show(0, 3, 0, 0);  check("corner_0_3", 16'(o_sel), 16'h5);
    show(3, 0, 0, 0);  check("corner_3_0", 16'(o_sel), 16'h5);
    show(0, 4, 0, 0);  check("corner_0_4", 16'(o_sel), 16'h0);
    show(0, 11, 0, 0); check("nowrap_0_11", 16'(o_sel), 16'h0);

    // Blanking wins over everything
    i_hblnk = 1'b1;
    show(0, 0, 5, 5);  check("hblnk_sel", 16'(o_sel), 16'hF);
    i_hblnk = 1'b0; i_vblnk = 1'b1;
    show(2, 2, 5, 5);  check("vblnk_sel", 16'(o_sel), 16'hF);
    i_vblnk = 1'b0;

    // Timing delay line: single-clock pulse appears exactly 4 clocks later
    i_hsync = 1'b1; i_hblnk = 1'b1;
    tick(1);
    i_hsync = 1'b0; i_hblnk = 1'b0;
    check("hs_d1", 16'(o_hsync), 16'h0);
    tick(2);
    check("hs_d3", 16'(o_hsync), 16'h0);
    tick(1);
    check("hs_d4", 16'(o_hsync), 16'h1);
    check("hb_d4", 16'(o_hblnk), 16'h1);
    check("vs_d4_idle", 16'(o_vsync), 16'h0);
    tick(1);
    check("hs_d5", 16'(o_hsync), 16'h0);

    // Off-map pixels
    i_hcount = 11'd1030; i_vcount = 11'd100;
    tick(1);
    check("oom_map_addr", 16'(o_map_addr), 16'h0);
    tick(1);
    check("oom_x_sel", 16'(o_sel), 16'h1);
    i_hcount = 11'd100; i_vcount = 11'd800;
    tick(2);
    check("oom_y_sel", 16'(o_sel), 16'h1);

    // Asynchronous reset mid-frame
    show(2, 2, 0, 0);
    check("pre_rst_sel", 16'(o_sel), 16'h0);
    i_hsync = 1'b1;
    tick(3);
    #2;
    i_rst = 1'b1;
    #1;
    check("async_rst_sel", 16'(o_sel), 16'hF);
    check("async_rst_hs", 16'(o_hsync), 16'h0);
    check("async_rst_addr", 16'(o_map_addr), 16'h0);
    i_hsync = 1'b0;
    tick(1);
    i_rst = 1'b0;
    show(0, 0, 0, 0);  check("shadow_clr_plr", 16'(o_sel), 16'h6);
    show(1, 0, 0, 0);  check("shadow_clr_expl", 16'(o_sel), 16'h0);
    show(15, 11, 0, 0); check("shadow_clr_old", 16'(o_sel), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
